// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the response-side slave multiplexer.
package ahb_pkg;

   // Master transfer types; bit 1 set marks an active (NONSEQ/SEQ) transfer.
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Six real slaves; index 6 of the data-phase select is the built-in default slave.
   localparam int NUM_SLAVES = 6;
   localparam int DFLT_IDX   = 6;

   // Default-slave progress through a two-cycle ERROR response.
   typedef enum logic [1:0] {
      D_IDLE = 2'b00,
      D_ERR1 = 2'b01,
      D_ERR2 = 2'b10
   } dflt_state_t;

   // Keeps only the lowest set bit, so overlapping decoder selects resolve to one slave.
   function automatic logic [NUM_SLAVES-1:0] lowest_one(input logic [NUM_SLAVES-1:0] v);
      logic [NUM_SLAVES-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (v[i] && (r == '0)) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// Bus-side signals of the slave multiplexer: decoder selects, slave responses, master response.
interface ahblite_slave_mux_if;

   logic [1:0]  HTRANS;

   logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL;
   logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT;
   logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP;
   logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA;

   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;

   // Surrounding system: master transfer type, decoder selects and slave responses.
   modport master (
      output HTRANS,
      output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL,
      output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT,
      output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP,
      output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA,
      input  HREADY, HRESP, HRDATA
   );

   // The multiplexer itself.
   modport slave (
      input  HTRANS,
      input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL,
      input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT, P5_HREADYOUT,
      input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP,
      input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA, P5_HRDATA,
      output HREADY, HRESP, HRDATA
   );

endinterface

// File: rtl/ahblite_default_slave.sv
// Default slave: answers active transfers to unmapped space with a two-cycle ERROR.
module ahblite_default_slave
   import ahb_pkg::*;
(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       HSEL,
   input  logic [1:0] HTRANS,
   input  logic       HREADY,
   output logic       HREADYOUT,
   output logic       HRESP
);

   dflt_state_t state_q;
   logic        accept_err;

   // An active transfer to unmapped space enters its data phase on this edge.
   assign accept_err = HREADY & HSEL & HTRANS[1];

   // State and registered outputs advance together; IDLE/BUSY to unmapped space stays OKAY.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q   <= D_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
      end else begin
         case (state_q)
            D_IDLE: begin
               if (accept_err) begin
                  state_q   <= D_ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= HRESP_ERROR;
               end
            end
            D_ERR1: begin
               state_q   <= D_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_ERROR;
            end
            D_ERR2: begin
               if (accept_err) begin
                  state_q   <= D_ERR1;
                  HREADYOUT <= 1'b0;
                  HRESP     <= HRESP_ERROR;
               end else begin
                  state_q   <= D_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= HRESP_OKAY;
               end
            end
            default: begin
               state_q   <= D_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= HRESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer: latches the decoder selects in the address phase and
// routes the owning slave's response to the master during the data phase.
module ahblite_slave_mux
   import ahb_pkg::*;
#(
   parameter logic [31:0] RDATA_IDLE = 32'h0000_0000
) (
   input  logic         HCLK,
   input  logic         HRESET,
   ahblite_slave_mux_if.slave bus
);

   logic [NUM_SLAVES-1:0]        hsel;
   logic [NUM_SLAVES-1:0]        slv_ready;
   logic [NUM_SLAVES-1:0]        slv_resp;
   logic [NUM_SLAVES-1:0][31:0]  slv_rdata;
   logic                         dflt;
   logic [NUM_SLAVES:0]          sel_q;
   logic                         dflt_ready;
   logic                         dflt_resp;
   logic                         hready;
   logic                         hresp;
   logic [31:0]                  hrdata;

   assign hsel      = {bus.P5_HSEL, bus.P4_HSEL, bus.P3_HSEL, bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
   assign slv_ready = {bus.P5_HREADYOUT, bus.P4_HREADYOUT, bus.P3_HREADYOUT,
                       bus.P2_HREADYOUT, bus.P1_HREADYOUT, bus.P0_HREADYOUT};
   assign slv_resp  = {bus.P5_HRESP, bus.P4_HRESP, bus.P3_HRESP,
                       bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
   assign slv_rdata = {bus.P5_HRDATA, bus.P4_HRDATA, bus.P3_HRDATA,
                       bus.P2_HRDATA, bus.P1_HRDATA, bus.P0_HRDATA};

   // No real slave claims the address: the default slave owns the next data phase.
   assign dflt = ~|hsel;

   // Capture the one-hot data-phase owner whenever the bus accepts a new address phase.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         sel_q <= '0;
      end else if (hready) begin
         // NOTE: non-blocking so this register samples the pre-edge HREADY and selects.
         sel_q <= {dflt, lowest_one(hsel)};
      end
   end

   ahblite_default_slave u_default_slave (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (dflt),
      .HTRANS    (bus.HTRANS),
      .HREADY    (hready),
      .HREADYOUT (dflt_ready),
      .HRESP     (dflt_resp)
   );

   // Route the data-phase owner's response; depends only on sel_q and registered/slave outputs.
   always_comb begin
      // NOTE: idle defaults first so every path assigns all outputs and no latch is inferred.
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      hrdata = RDATA_IDLE;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (sel_q[i]) begin
            hready = slv_ready[i];
            hresp  = slv_resp[i];
            hrdata = slv_rdata[i];
         end
      end
      if (sel_q[DFLT_IDX]) begin
         hready = dflt_ready;
         hresp  = dflt_resp;
      end
   end

   assign bus.HREADY = hready;
   assign bus.HRESP  = hresp;
   assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench: stimulus pushes each cycle's inputs into a queue; a negedge monitor
// pops them, predicts the response from a transaction-level model and compares.
module tb_ahblite_slave_mux;

   typedef struct {
      logic [5:0]       hsel;
      logic [1:0]       htrans;
      logic [5:0]       rdy;
      logic [5:0]       rsp;
      logic [5:0][31:0] data;
   } stim_rec_t;

   logic clk;
   logic rst;

   ahblite_slave_mux_if bus ();

   ahblite_slave_mux #(.RDATA_IDLE(32'h0000_0000)) dut (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Values each slave presents this cycle.
   logic [5:0]       slv_rdy;
   logic [5:0]       slv_rsp;
   logic [5:0][31:0] slv_data;

   stim_rec_t stim_q[$];
   bit        mon_en = 1'b0;

   // Reference model: who owns the data phase and how far into it we are.
   int m_owner;      // -1 none, 0..5 slave, 6 default slave
   bit m_err;        // default-slave phase belongs to an active transfer
   int m_dcyc;       // cycles already spent in the current data phase

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_inputs(input logic [5:0] hsel, input logic [1:0] htrans);
      bus.HTRANS       = htrans;
      bus.P0_HSEL      = hsel[0];
      bus.P1_HSEL      = hsel[1];
      bus.P2_HSEL      = hsel[2];
      bus.P3_HSEL      = hsel[3];
      bus.P4_HSEL      = hsel[4];
      bus.P5_HSEL      = hsel[5];
      bus.P0_HREADYOUT = slv_rdy[0];
      bus.P1_HREADYOUT = slv_rdy[1];
      bus.P2_HREADYOUT = slv_rdy[2];
      bus.P3_HREADYOUT = slv_rdy[3];
      bus.P4_HREADYOUT = slv_rdy[4];
      bus.P5_HREADYOUT = slv_rdy[5];
      bus.P0_HRESP     = slv_rsp[0];
      bus.P1_HRESP     = slv_rsp[1];
      bus.P2_HRESP     = slv_rsp[2];
      bus.P3_HRESP     = slv_rsp[3];
      bus.P4_HRESP     = slv_rsp[4];
      bus.P5_HRESP     = slv_rsp[5];
      bus.P0_HRDATA    = slv_data[0];
      bus.P1_HRDATA    = slv_data[1];
      bus.P2_HRDATA    = slv_data[2];
      bus.P3_HRDATA    = slv_data[3];
      bus.P4_HRDATA    = slv_data[4];
      bus.P5_HRDATA    = slv_data[5];
   endtask

   // One bus cycle: new inputs just after the rising edge, recorded for the monitor.
   task automatic drive(input logic [5:0] hsel, input logic [1:0] htrans);
      stim_rec_t r;
      @(posedge clk);
      #1;
      apply_inputs(hsel, htrans);
      r.hsel   = hsel;
      r.htrans = htrans;
      r.rdy    = slv_rdy;
      r.rsp    = slv_rsp;
      r.data   = slv_data;
      if (mon_en) stim_q.push_back(r);
   endtask

   // Monitor: predict the response of this cycle, compare, then advance the model.
   always @(negedge clk) begin
      stim_rec_t r;
      logic      e_rdy, e_rsp;
      logic [31:0] e_data;
      if (mon_en) begin
         if (stim_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stim_queue: got empty queue expected one record at %0t", $time);
         end else begin
            r = stim_q.pop_front();
            e_rdy  = 1'b1;
            e_rsp  = 1'b0;
            e_data = 32'h0;
            if (m_owner >= 0 && m_owner < 6) begin
               e_rdy  = r.rdy[m_owner];
               e_rsp  = r.rsp[m_owner];
               e_data = r.data[m_owner];
            end else if (m_owner == 6 && m_err) begin
               // ERROR takes two cycles: first with wait state, second completes.
               e_rdy = (m_dcyc != 0);
               e_rsp = 1'b1;
            end
            check("HREADY", {31'b0, bus.HREADY}, {31'b0, e_rdy});
            check("HRESP",  {31'b0, bus.HRESP},  {31'b0, e_rsp});
            check("HRDATA", bus.HRDATA, e_data);
            if (e_rdy) begin
               m_dcyc = 0;
               if (r.hsel == 6'b0) begin
                  m_owner = 6;
                  m_err   = r.htrans[1];
               end else begin
                  m_err = 1'b0;
                  for (int i = 5; i >= 0; i--) if (r.hsel[i]) m_owner = i;
               end
            end else begin
               m_dcyc++;
            end
         end
      end
   end

   task automatic model_reset();
      m_owner = -1;
      m_err   = 1'b0;
      m_dcyc  = 0;
      stim_q.delete();
   endtask

   task automatic all_ready();
      slv_rdy = 6'b111111;
      slv_rsp = 6'b000000;
   endtask

   initial begin
      logic [5:0] hs;
      int         mode;

      model_reset();
      slv_rdy  = 6'b000000;
      slv_rsp  = 6'b111111;
      for (int i = 0; i < 6; i++) slv_data[i] = 32'hA5A5_0000 + i;
      rst = 1'b1;
      apply_inputs(6'b0, 2'b00);

      // Reset state.
      #3;
      check("reset_HREADY", {31'b0, bus.HREADY}, 32'd1);
      check("reset_HRESP",  {31'b0, bus.HRESP},  32'd0);
      check("reset_HRDATA", bus.HRDATA, 32'h0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      mon_en = 1'b1;

      // Read hit on P1.
      all_ready();
      slv_data[1] = 32'hDEAD_BEEF;
      drive(6'b000010, 2'b10);
      drive(6'b000000, 2'b00);

      // Wait states on P3 while P0 is presented.
      drive(6'b001000, 2'b10);
      slv_rdy[3] = 1'b0; slv_data[3] = 32'h3333_0001;
      drive(6'b000001, 2'b10);
      slv_data[3] = 32'h3333_0002;
      drive(6'b000001, 2'b10);
      slv_rdy[3] = 1'b1; slv_data[3] = 32'h3333_0003;
      drive(6'b000001, 2'b10);
      slv_data[0] = 32'h0000_00C0;
      drive(6'b000000, 2'b00);

      // Unmapped active transfer: ERR1, ERR2, OKAY.
      drive(6'b000000, 2'b10);
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b00);

      // Back-to-back unmapped, then IDLE/BUSY to unmapped space.
      drive(6'b000000, 2'b10);
      drive(6'b000000, 2'b10);
      drive(6'b000000, 2'b11);
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b01);
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b00);

      // Overlapping selects: P2 wins over P4.
      slv_data[2] = 32'h2222_2222;
      slv_data[4] = 32'h1234_5678;
      drive(6'b010100, 2'b10);
      drive(6'b000000, 2'b00);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 6; i++) begin
            slv_rdy[i]  = ($urandom_range(0, 3) != 0);
            slv_rsp[i]  = $urandom_range(0, 1) == 1;
            slv_data[i] = $urandom;
         end
         mode = $urandom_range(0, 3);
         if (mode == 0)      hs = 6'b0;
         else if (mode == 3) hs = 6'($urandom);
         else                hs = 6'b1 << $urandom_range(0, 5);
         drive(hs, 2'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of a P3 wait state.
      all_ready();
      drive(6'b001000, 2'b10);
      slv_rdy[3] = 1'b0; slv_data[3] = 32'hBAD0_0003;
      drive(6'b000000, 2'b00);
      @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check("midreset_HREADY", {31'b0, bus.HREADY}, 32'd1);
      check("midreset_HRESP",  {31'b0, bus.HRESP},  32'd0);
      check("midreset_HRDATA", bus.HRDATA, 32'h0);
      model_reset();
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b00);
      @(negedge clk);
      #2 rst = 1'b0;
      mon_en = 1'b1;
      all_ready();
      slv_data[1] = 32'h0101_0101;
      drive(6'b000010, 2'b10);
      drive(6'b000000, 2'b00);
      drive(6'b000000, 2'b00);
      @(negedge clk);
      #2 mon_en = 1'b0;

      if (stim_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL stim_drain: got %0d leftover records expected 0", stim_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
